// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - N-bit multicycle ALU with start/busy/done handshake.
// Optional iterative unsigned multiply is built when ULA_MUL_EN is defined.
module ula_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ALUop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             cout,
  output logic             overf,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             overf_q, overf_d;

  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_w;
  logic             add_ov;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ov;

`ifdef ULA_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;

  // Carry of the partial add lands in the top bit and is shifted into acc.
  assign mul_sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign hi      = hi_q;
  assign busy    = (state_q == S_MUL);
`else
  assign hi   = '0;
  assign busy = 1'b0;
`endif

  always_comb begin
    sub_op   = (ALUop == OP_SUB) || (ALUop == OP_SLT);
    b_eff    = sub_op ? ~b : b;
    sum_w    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    add_ov   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ov   = 1'b0;
    case (ALUop)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD, OP_SUB: begin
        alu_res  = sum_w[WIDTH-1:0];
        alu_cout = sum_w[WIDTH];
        alu_ov   = add_ov;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, sum_w[WIDTH-1] ^ add_ov};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    overf_d  = overf_q;
`ifdef ULA_MUL_EN
    hi_d     = hi_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
`ifdef ULA_MUL_EN
          if (ALUop == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else
`endif
          begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            cout_d   = alu_cout;
            overf_d  = alu_ov;
`ifdef ULA_MUL_EN
            hi_d     = '0;
`endif
            state_d  = S_DONE;
          end
        end
      end
`ifdef ULA_MUL_EN
      S_MUL: begin
        acc_d    = mul_sum[WIDTH:1];
        mplier_d = {mul_sum[0], mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          hi_d     = acc_d;
          result_d = mplier_d;
          zero_d   = ({acc_d, mplier_d} == '0);
          cout_d   = 1'b0;
          overf_d  = 1'b0;
          state_d  = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      overf_q  <= 1'b0;
`ifdef ULA_MUL_EN
      hi_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      overf_q  <= overf_d;
`ifdef ULA_MUL_EN
      hi_q     <= hi_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign cout   = cout_q;
  assign overf  = overf_q;
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - directed self-checking bench for ula_multiciclo, WIDTH=8.
// MUL vectors run when ULA_MUL_EN is defined; otherwise ALUop 011 is checked as reserved.
module tb_ula_multiciclo;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   ALUop = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic [W-1:0] hi;
  logic         zero, cout, overf, busy, done;

  int checks   = 0;
  int failures = 0;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .ALUop(ALUop),
    .a(a), .b(b), .result(result), .hi(hi), .zero(zero),
    .cout(cout), .overf(overf), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request; start stays high so consecutive calls are back-to-back.
  task automatic op(input logic [2:0] opc, input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clock);
    start = 1'b1;
    ALUop = opc;
    a     = va;
    b     = vb;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_result"}, 32'(result), 32'h00);
    check({tag, "_hi"},     32'(hi),     32'h00);
    check({tag, "_zero"},   32'(zero),   32'h1);
    check({tag, "_cout"},   32'(cout),   32'h0);
    check({tag, "_overf"},  32'(overf),  32'h0);
    check({tag, "_busy"},   32'(busy),   32'h0);
    check({tag, "_done"},   32'(done),   32'h0);
  endtask

  int busy_cnt;
  int done_cnt;
  int done_edge;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("rst0");
    @(negedge clock);
    reset = 1'b0;

    op(3'b010, 8'h7F, 8'h01);
    check("add_res",   32'(result), 32'h80);
    check("add_overf", 32'(overf),  32'h1);
    check("add_cout",  32'(cout),   32'h0);
    check("add_zero",  32'(zero),   32'h0);
    check("add_done",  32'(done),   32'h1);
    idle();
    check("add_done_pulse", 32'(done), 32'h0);
    check("add_hold",       32'(result), 32'h80);

    op(3'b110, 8'h05, 8'h05);
    check("sub0_res",   32'(result), 32'h00);
    check("sub0_zero",  32'(zero),   32'h1);
    check("sub0_cout",  32'(cout),   32'h1);
    check("sub0_overf", 32'(overf),  32'h0);
    op(3'b110, 8'h80, 8'h01);
    check("sub1_res",   32'(result), 32'h7F);
    check("sub1_overf", 32'(overf),  32'h1);
    check("sub1_done",  32'(done),   32'h1);

    op(3'b111, 8'h80, 8'h01);
    check("slt0_res",   32'(result), 32'h01);
    check("slt0_overf", 32'(overf),  32'h0);
    check("slt0_cout",  32'(cout),   32'h0);
    op(3'b111, 8'h7F, 8'h80);
    check("slt1_res",   32'(result), 32'h00);
    check("slt1_overf", 32'(overf),  32'h0);
    op(3'b111, 8'h03, 8'h03);
    check("slt2_res",   32'(result), 32'h00);
    check("slt2_overf", 32'(overf),  32'h0);
    check("slt2_done",  32'(done),   32'h1);

    op(3'b001, 8'h0F, 8'hF0);
    check("or_res", 32'(result), 32'hFF);
    op(3'b100, 8'h0F, 8'hF0);
    check("nor_res",  32'(result), 32'h00);
    check("nor_zero", 32'(zero),   32'h1);
    op(3'b010, 8'hFF, 8'h01);
    check("addc_res",   32'(result), 32'h00);
    check("addc_cout",  32'(cout),   32'h1);
    check("addc_overf", 32'(overf),  32'h0);
    op(3'b101, 8'h12, 8'h34);
    check("rsv_res",  32'(result), 32'h00);
    check("rsv_hi",   32'(hi),     32'h00);
    check("rsv_zero", 32'(zero),   32'h1);
    check("rsv_cout", 32'(cout),   32'h0);
    idle();

`ifdef ULA_MUL_EN
    op(3'b011, 8'hFF, 8'hFF);
    check("mul_busy_e0", 32'(busy), 32'h1);
    check("mul_done_e0", 32'(done), 32'h0);
    busy_cnt  = 1;
    done_cnt  = 0;
    done_edge = 0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      start = (i == 3);
      ALUop = 3'b010;
      @(posedge clock);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_edge = i;
      end
    end
    check("mul_busy_cycles", 32'(busy_cnt),  32'd8);
    check("mul_done_count",  32'(done_cnt),  32'd1);
    check("mul_done_edge",   32'(done_edge), 32'd8);
    check("mul_res",  32'(result), 32'h01);
    check("mul_hi",   32'(hi),     32'hFE);
    check("mul_zero", 32'(zero),   32'h0);

    op(3'b011, 8'h0C, 8'h0A);
    check("mul2_busy", 32'(busy), 32'h1);
    repeat (3) idle();
`else
    op(3'b011, 8'h02, 8'h03);
    check("m11_res",  32'(result), 32'h00);
    check("m11_hi",   32'(hi),     32'h00);
    check("m11_zero", 32'(zero),   32'h1);
    check("m11_busy", 32'(busy),   32'h0);
    check("m11_done", 32'(done),   32'h1);
    idle();
    check("m11_busy_after", 32'(busy), 32'h0);
    check("m11_done_pulse", 32'(done), 32'h0);
    op(3'b010, 8'h7F, 8'h01);
    check("pre_rst_res", 32'(result), 32'h80);
    idle();
`endif

    @(negedge clock);
    reset = 1'b1;
    #2;
    check_reset_state("rst_async");
    @(negedge clock);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      if (done) done_cnt++;
    end
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_busy",    32'(busy),     32'h0);

    op(3'b000, 8'hF0, 8'h3C);
    check("and_res",  32'(result), 32'h30);
    check("and_done", 32'(done),   32'h1);
    check("and_hi",   32'(hi),     32'h00);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised N-bit ALU that succeeds the 1-bit ALU slice. It performs AND, OR, NOR, ADD, SUB, SLT and an optional iterative unsigned multiply. The block has a start/busy/done handshake and registered results and flags. It sits in the multicycle datapath between the register-file read stage and the write-back mux.

## Interface
- WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only when the FSM is in IDLE or DONE.
- ALUop  in  3  operation select, sampled with start:
  - 000 AND; 001 OR; 010 ADD; 011 MUL; 100 NOR; 101 reserved; 110 SUB; 111 SLT.
- a  in  WIDTH  operand A, sampled with start.
- b  in  WIDTH  operand B, sampled with start.
- result  out  WIDTH  registered result; low word for MUL.
- hi  out  WIDTH  registered high word of the MUL product; 0 after any other op.
- zero  out  1  result==0 for non-MUL ops; {hi,result}==0 for MUL.
- cout  out  1  carry out of the MSB adder for ADD/SUB; 0 otherwise.
- overf  out  1  signed two's-complement overflow for ADD/SUB; 0 otherwise.
- busy  out  1  high while a MUL is iterating.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - MUL: iterating a multiply.
  - DONE: one cycle, done=1.
- From IDLE or DONE with start=1:
  - Non-MUL op: compute combinationally from a/b and register outputs at that edge, then go to DONE.
  - MUL: latch a (multiplicand) and b (multiplier), clear the accumulator and the counter, set busy=1, go to MUL.
- From DONE with start=0: go to IDLE.
- Arithmetic:
  - ADD is a+b.
  - SUB is a+~b+1, so cout=1 means no borrow.
  - overf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the effective B.
- SLT: result = {WIDTH-1 zeros, sub[MSB] ^ sub_overflow}, i.e. a correct signed a<b. cout=0 and overf=0.
- Reserved op 101: result=0, hi=0, flags 0 except zero=1. Completes like a non-MUL op.
- MUL is an unsigned shift-add:
  - Each cycle in MUL: if multiplier LSB=1, add the multiplicand to the upper accumulator half (carry kept in a WIDTH+1-bit sum).
  - Then shift the {carry,acc,multiplier} register right 1 and increment the counter.
  - After WIDTH iterations: write hi/result from the 2·WIDTH product, busy=0, go to DONE.
- Counter width is clog2(WIDTH)+1.
- start while busy=1 is ignored; no queuing.
- Outputs hold their last completed values until the next completion.
- reset (any time, including mid-MUL):
  - Forces IDLE.
  - result=0, hi=0, cout=0, overf=0, busy=0, done=0, zero=1.
  - The in-flight MUL is discarded and produces no done.

## Timing
- Non-MUL latency: start sampled at edge E0. Outputs valid and done=1 after E0, for exactly one cycle.
- MUL latency:
  - busy=1 after E0.
  - Iterations occur at edges E1..EWIDTH.
  - busy=0, done=1, and result/hi valid after edge EWIDTH, so done is high for the cycle following EWIDTH.
- Back-to-back: start=1 during the done cycle is accepted. Throughput is one non-MUL op per cycle.
- No combinational path from inputs to outputs.

## Configuration
- ULA_MUL_EN defined: MUL as described; busy and hi functional.
- ULA_MUL_EN undefined:
  - The MUL state and shift-add datapath are removed.
  - ALUop 011 behaves as reserved (result=0, hi=0, zero=1, done after 1 cycle).
  - busy is tied to 0 and hi is tied to 0.

## Test plan
- WIDTH=8, ADD a=8'h7F b=8'h01 -> result=8'h80, overf=1, cout=0, zero=0; done high exactly the cycle after the start edge.
- SUB a=8'h05 b=8'h05 -> result=8'h00, zero=1, cout=1, overf=0. Then SUB a=8'h80 b=8'h01 -> result=8'h7F, overf=1.
- SLT:
  - a=8'h80 b=8'h01 -> result=8'h01.
  - a=8'h7F b=8'h80 -> result=8'h00.
  - a=8'h03 b=8'h03 -> result=8'h00.
  - In all cases overf=0.
- MUL a=8'hFF b=8'hFF -> hi=8'hFE, result=8'h01, busy for 8 cycles, done after edge E8. A second start pulse during busy is ignored (single done observed).
- MUL a=8'h0C b=8'h0A with reset pulsed after iteration 3:
  - All outputs return to reset values (zero=1) and no done appears.
  - A subsequent AND a=8'hF0 b=8'h3C gives result=8'h30 one cycle later.
- Build without ULA_MUL_EN, ALUop=011 a=8'h02 b=8'h03 -> result=0, hi=0, zero=1, busy never asserted, done one cycle after start.
